// File: rtl/m4_frame_pkg.sv
// Shared frame geometry, serializer state encoding and pointer arithmetic
// for the M4 telemetry frame path.
package m4_frame_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned PTR_W  = 9;
  localparam int unsigned GRP_W  = 5;
  localparam int unsigned WORDS  = 512;
  localparam int unsigned GROUPS = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } ser_state_t;

  typedef struct packed {
    logic [PTR_W-1:0] ptr;
    logic [GRP_W-1:0] grp;
  } frame_pos_t;

  // Next (pointer, group) pair; the group advances only when the pointer wraps.
  function automatic frame_pos_t ptr_next(
    input logic [PTR_W-1:0] ptr,
    input logic [GRP_W-1:0] grp,
    input int unsigned      words,
    input int unsigned      groups
  );
    frame_pos_t nxt;
    nxt.grp = grp;
    if (ptr == PTR_W'(words - 1)) begin
      nxt.ptr = '0;
      nxt.grp = (grp == GRP_W'(groups - 1)) ? '0 : grp + 1'b1;
    end else begin
      nxt.ptr = ptr + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/m4_bit_tick.sv
// Serial bit-period divider: counts 0..CLK_DIV-1 while running and flags the
// first and last clk of every bit period.
module m4_bit_tick #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic reset,
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic tick_first,
  output logic tick_last
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  // Divider counter, held at zero while the serializer is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  // Bit-period boundary flags, only meaningful while running.
  always_comb begin
    tick_first = run && (div_cnt == '0);
    tick_last  = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  end

endmodule

// File: rtl/m4_word_serializer.sv
// Pulls telemetry words from the M4 word filler in frame order and shifts
// them out MSB-first as a gapless NRZ stream, one bit every CLK_DIV clks.
module m4_word_serializer #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned WORD_W  = m4_frame_pkg::WORD_W,
  parameter int unsigned WORDS   = m4_frame_pkg::WORDS,
  parameter int unsigned GROUPS  = m4_frame_pkg::GROUPS
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           enable,
  input  logic [WORD_W-1:0]              data_word,
  output logic                           get_word,
  output logic [m4_frame_pkg::PTR_W-1:0] rd_ptr,
  output logic [m4_frame_pkg::GRP_W-1:0] cnt_grp,
  output logic                           sdata,
  output logic                           word_strobe,
  output logic                           frame_strobe,
  output logic                           busy
);

  import m4_frame_pkg::*;

  localparam int unsigned BIT_W = $clog2(WORD_W);

  ser_state_t        state;
  logic              get_d1;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] hold;
  logic [PTR_W-1:0]  tag;
  logic [PTR_W-1:0]  hold_tag;
  logic [BIT_W-1:0]  bit_cnt;
  frame_pos_t        pos_next;
  logic              tick_clear;
  logic              tick_run;
  logic              tick_first;
  logic              tick_last;

  // Divider control follows the FSM state.
  always_comb begin
    tick_clear = (state == IDLE);
    tick_run   = (state == RUN);
    pos_next   = ptr_next(rd_ptr, cnt_grp, WORDS, GROUPS);
  end

  m4_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .reset      (reset),
    .clk        (clk),
    .clear      (tick_clear),
    .run        (tick_run),
    .tick_first (tick_first),
    .tick_last  (tick_last)
  );

  // Strobes are decoded from registered state (first clk of the MSB period),
  // so they line up with sdata without an extra pipeline stage.
  always_comb begin
    word_strobe  = tick_first && (bit_cnt == '0);
    frame_strobe = word_strobe && (tag == '0);
  end

  // Serializer FSM: request, capture, shift and prefetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      get_word <= 1'b0;
      get_d1   <= 1'b0;
      rd_ptr   <= '0;
      cnt_grp  <= '0;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      shift    <= '0;
      hold     <= '0;
      tag      <= '0;
      hold_tag <= '0;
      bit_cnt  <= '0;
    end else begin
      get_word <= 1'b0;
      if ((state != IDLE) && !enable) begin
        // Abandon the current word and any in-flight prefetch.
        state   <= IDLE;
        get_d1  <= 1'b0;
        rd_ptr  <= '0;
        cnt_grp <= '0;
        sdata   <= 1'b0;
        busy    <= 1'b0;
        shift   <= '0;
        hold    <= '0;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            get_d1 <= 1'b0;
            if (enable) begin
              get_word <= 1'b1;
              busy     <= 1'b1;
              state    <= PRIME;
            end
          end
          PRIME: begin
            get_d1 <= get_word;
            if (get_d1) begin
              shift   <= data_word;
              sdata   <= data_word[WORD_W-1];
              tag     <= rd_ptr;
              bit_cnt <= '0;
              rd_ptr  <= pos_next.ptr;
              cnt_grp <= pos_next.grp;
              state   <= RUN;
            end
          end
          RUN: begin
            get_d1 <= get_word;
            if (get_d1) begin
              hold     <= data_word;
              hold_tag <= rd_ptr;
              rd_ptr   <= pos_next.ptr;
              cnt_grp  <= pos_next.grp;
            end
            if (tick_last) begin
              if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                shift   <= hold;
                sdata   <= hold[WORD_W-1];
                tag     <= hold_tag;
                bit_cnt <= '0;
              end else begin
                shift   <= {shift[WORD_W-2:0], 1'b0};
                sdata   <= shift[WORD_W-2];
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BIT_W'(WORD_W - 2)) begin
                  get_word <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m4_word_serializer.sv
// Directed bench for m4_word_serializer: a full-size instance for stream,
// pointer and abort behaviour, plus a reduced-frame instance for group wrap.
module tb_m4_word_serializer;

  localparam int DIV   = 4;
  localparam int WW    = 12;
  localparam int BPW   = WW * DIV;
  localparam int REQ_K = (WW - 1) * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        enable_s;
  logic [11:0] data_word   = '0;
  logic [11:0] data_word_s = '0;

  logic       get_word, sdata, word_strobe, frame_strobe, busy;
  logic [8:0] rd_ptr;
  logic [4:0] cnt_grp;
  logic       get_word_s, sdata_s, word_strobe_s, frame_strobe_s, busy_s;
  logic [8:0] rd_ptr_s;
  logic [4:0] cnt_grp_s;

  int vectors     = 0;
  int miscompares = 0;
  int ws_cnt, fs_cnt;

  always #5 clk = ~clk;

  m4_word_serializer #(.CLK_DIV(DIV)) dut (
    .reset        (reset),
    .clk          (clk),
    .enable       (enable),
    .data_word    (data_word),
    .get_word     (get_word),
    .rd_ptr       (rd_ptr),
    .cnt_grp      (cnt_grp),
    .sdata        (sdata),
    .word_strobe  (word_strobe),
    .frame_strobe (frame_strobe),
    .busy         (busy)
  );

  m4_word_serializer #(.CLK_DIV(DIV), .WORDS(8), .GROUPS(4)) dut_s (
    .reset        (reset),
    .clk          (clk),
    .enable       (enable_s),
    .data_word    (data_word_s),
    .get_word     (get_word_s),
    .rd_ptr       (rd_ptr_s),
    .cnt_grp      (cnt_grp_s),
    .sdata        (sdata_s),
    .word_strobe  (word_strobe_s),
    .frame_strobe (frame_strobe_s),
    .busy         (busy_s)
  );

  function automatic logic [11:0] fill(input logic [8:0] p);
    return (p == 9'd0) ? 12'hA5C : {3'b000, p};
  endfunction

  // Filler models: data registered one clk after the request.
  always @(posedge clk) if (get_word)   data_word   <= fill(rd_ptr);
  always @(posedge clk) if (get_word_s) data_word_s <= fill(rd_ptr_s);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] obs_bits(input bit sel);
    return sel ? {sdata_s, word_strobe_s, frame_strobe_s, get_word_s, busy_s}
               : {sdata, word_strobe, frame_strobe, get_word, busy};
  endfunction

  function automatic logic [13:0] obs_pos(input bit sel);
    return sel ? {rd_ptr_s, cnt_grp_s} : {rd_ptr, cnt_grp};
  endfunction

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk(tag, 32'({get_word, sdata, word_strobe, frame_strobe, busy, rd_ptr, cnt_grp}), 32'd0);
  endtask

  // Caller raises enable at a negedge; checks request, latency and stream.
  task automatic run_stream(input bit sel, input int words, input int groups, input int ncyc);
    logic [4:0]  o;
    logic [11:0] ew;
    logic        eb;
    int          w, k;
    @(negedge clk);
    chk("c1_req", 32'(obs_bits(sel)), 32'(5'b00011));
    chk("c1_pos", 32'(obs_pos(sel)), 32'd0);
    @(negedge clk);
    chk("c2_wait", 32'(obs_bits(sel)), 32'(5'b00001));
    ws_cnt = 0;
    fs_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      w  = c / BPW;
      k  = c % BPW;
      ew = fill(9'(w % words));
      eb = ew[WW - 1 - k / DIV];
      o  = obs_bits(sel);
      if (o[3]) ws_cnt++;
      if (o[2]) fs_cnt++;
      chk($sformatf("stream%0d w%0d k%0d", sel, w, k), 32'(o),
          32'({eb, k == 0, (k == 0) && (w % words == 0), k == REQ_K, 1'b1}));
      if (k == REQ_K)
        chk($sformatf("req_pos%0d w%0d", sel, w + 1), 32'(obs_pos(sel)),
            32'({9'((w + 1) % words), 5'(((w + 1) / words) % groups)}));
    end
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    enable_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_get_word", 32'(get_word), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_cnt_grp", 32'(cnt_grp), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_word_strobe", 32'(word_strobe), 32'd0);
    chk("rst_frame_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) idle_check("idle_after_reset");

    // Long run through a pointer wrap; stop at k=44 of word 520 (request out).
    enable = 1'b1;
    run_stream(1'b0, 512, 32, 520 * BPW + REQ_K + 1);
    chk("ws_count", 32'(ws_cnt), 32'd521);
    chk("fs_count", 32'(fs_cnt), 32'd2);

    // Abort during bit 0 right after the prefetch request, re-enable at once.
    enable = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({get_word, sdata, word_strobe, frame_strobe, busy}), 32'd0);
    chk("abort_pos", 32'({rd_ptr, cnt_grp}), 32'd0);
    enable = 1'b1;
    run_stream(1'b0, 512, 32, 100);

    // Abort mid-bit and stay idle: no further requests.
    enable = 1'b0;
    for (int i = 0; i < 60; i++) idle_check("idle_after_abort");

    // Asynchronous reset in the middle of a run.
    enable = 1'b1;
    run_stream(1'b0, 512, 32, 20);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({get_word, sdata, word_strobe, frame_strobe, busy}), 32'd0);
    chk("async_rst_pos", 32'({rd_ptr, cnt_grp}), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) idle_check("idle_after_reset2");

    // Reduced frame: 8 words x 4 groups, run past the full group wrap.
    enable_s = 1'b1;
    run_stream(1'b1, 8, 4, 34 * BPW + REQ_K + 1);
    chk("small_ws_count", 32'(ws_cnt), 32'd35);
    chk("small_fs_count", 32'(fs_cnt), 32'd5);
    enable_s = 1'b0;
    @(negedge clk);
    chk("small_idle", 32'({get_word_s, sdata_s, busy_s, rd_ptr_s, cnt_grp_s}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m4_word_serializer.md
Name: m4_word_serializer

Overview:
Downstream consumer of the M4 word filler, and source of its read strobe and its pointer/group context. Pulls 12-bit telemetry words in frame order and shifts them out MSB-first as an NRZ bit stream at clk/CLK_DIV. Prefetches each word into a hold register so the serial output has no gaps. Maintains word pointer (0..WORDS-1) and group counter (0..GROUPS-1).

Parameters:
CLK_DIV, 8, clk cycles per serial bit; legal range 4..255
WORD_W, 12, bits per word
WORDS, 512, words per frame; pointer wraps after WORDS-1
GROUPS, 32, frames per group cycle; cnt_grp wraps after GROUPS-1

Ports:
reset  in  1  asynchronous, active-low reset
clk  in  1  system clock
enable  in  1  run request; level-sensitive
data_word  in  WORD_W  word from filler; registered by filler one clk after get_word
get_word  out  1  one-clk request strobe to filler
rd_ptr  out  9  address of requested word; stable while get_word=1
cnt_grp  out  5  frame-group index, presented with rd_ptr
sdata  out  1  serial data, MSB first
word_strobe  out  1  one-clk pulse on the first clk of each word's MSB
frame_strobe  out  1  word_strobe qualified by that word's pointer == 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset=0): all outputs 0; shift/hold registers 0; bit divider 0; state IDLE.
- States: IDLE, PRIME, RUN.
- IDLE:
  - Outputs held at 0; rd_ptr=0 and cnt_grp=0.
  - enable=1 -> assert get_word for 1 clk with rd_ptr=0, go to PRIME.
- Capture rule:
  - With get_word high in cycle N, data_word is sampled at the end of cycle N+1 (the filler's register delay).
  - rd_ptr advances at the end of cycle N+1.
- Pointer arithmetic:
  - rd_ptr next = rd_ptr+1, or 0 if rd_ptr==WORDS-1.
  - On that wrap, cnt_grp next = cnt_grp+1, or 0 if cnt_grp==GROUPS-1.
- PRIME:
  - Captured word goes straight into the shift register; go to RUN.
  - In the first RUN clk: word_strobe=1, frame_strobe=1, sdata=bit 11.
  - First-bit latency after enable sampled high: 3 clk.
- RUN, bit timing:
  - Divider counts 0..CLK_DIV-1; each bit is held exactly CLK_DIV clks.
  - After bit 0 (LSB) completes, the next word's bit 11 is output on the following clk.
- RUN, prefetch:
  - get_word pulses in the first clk of the bit-0 period; the result is captured into the hold register two clks later.
  - At the end of the bit-0 period, the shift register loads from the hold register.
  - word_strobe pulses with the new MSB; frame_strobe pulses if the loaded word's pointer was 0.
  - The pointer of each word is tracked alongside it in a tag register.
- enable deassert:
  - Sampled low in RUN or PRIME -> go to IDLE next clk, abandoning the current word.
  - sdata=0, busy=0, rd_ptr=0, cnt_grp=0.
  - No get_word is issued in that clk or after. An in-flight prefetch is discarded.
- enable high continuously: the stream is periodic. Group counter increments once per WORDS words.
- enable re-asserted in the same clk it would drop: level sampled each clk; IDLE is always entered for at least 1 clk.
- get_word is never asserted on two consecutive clks.

Decomposition:
- Package m4_frame_pkg:
  - WORD_W, PTR_W=9, GRP_W=5, WORDS, GROUPS localparams.
  - State enum {IDLE, PRIME, RUN}.
  - Function ptr_next(ptr, grp) returning the wrapped pair; shared with the filler bench.
- Sub-module m4_bit_tick: CLK_DIV divider.
  - Outputs tick_first (first clk of a bit) and tick_last (last clk of a bit).
  - Synchronous clear while the serializer is in IDLE.

Test Plan:
- Reset/idle: reset low mid-RUN -> all outputs 0 on the same clk; after release with enable=0, outputs stay 0 for 100 clk.
- First word: CLK_DIV=4, data_word model returns 12'hA5C for ptr 0.
  - get_word at clk 1.
  - sdata=1,0,1,0,0,1,0,1,1,1,0,0 each for 4 clk, starting clk 3.
  - word_strobe and frame_strobe at clk 3.
- Gapless prefetch: model returns rd_ptr value as data.
  - Consecutive words are contiguous on sdata with no extra clk.
  - get_word spacing is exactly 12*CLK_DIV clk.
- Pointer and group wrap: run 512 words.
  - rd_ptr 511 -> 0 and cnt_grp 0 -> 1.
  - frame_strobe exactly once per 512 word_strobes.
- Group wrap: force 32 frames; cnt_grp 31 -> 0 with rd_ptr 511 -> 0 on the same request.
- Abort: drop enable during bit 0 after get_word.
  - Next clk: IDLE, sdata=0, no further get_word.
  - Re-enable -> next request has rd_ptr=0, cnt_grp=0.
